// File: rtl/regs_writeback.sv
// Write-back sequencer: buffers execute write requests in an in-order FIFO and drains one per enabled cycle onto the register-file write port.
// Define REGS_WRITEBACK_BYPASS_EN to build the read-port forwarding comparators; otherwise the fwd outputs are tied to 0.
module regs_writeback #(
    parameter int DEPTH     = 4,
    parameter int ACC_COUNT = 6
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_isRegW,
    input  logic [2:0]               in_reg,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_bits,
    input  logic [2:0]               in_bitval,
    input  logic                     drain_en,
    output logic                     isWrite,
    output logic [2:0]               writeReg,
    output logic                     isRegW,
    output logic [2:0]               dataSel,
    output logic [7:0]               writeData1,
    output logic                     writeFlip,
    output logic                     writeFlag,
    output logic                     writeBit,
    output logic                     flipin,
    output logic                     flagin,
    output logic                     bitin,
    input  logic [2:0]               rd1_reg,
    input  logic [2:0]               rd2_reg,
    input  logic                     rd1_isReg,
    input  logic                     rd2_isReg,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [7:0]               fwd1_data,
    output logic [7:0]               fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] ACC_LIMIT = 4'(ACC_COUNT);

    logic [7:0]       dataMem   [DEPTH];
    logic [2:0]       regMem    [DEPTH];
    logic             isRegMem  [DEPTH];
    logic             hasRegMem [DEPTH];
    logic [2:0]       bitsMem   [DEPTH];
    logic [2:0]       bitvalMem [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             pop;
    logic             push;
    logic             illegal;
    logic             store;

    assign pop      = drain_en && (count != '0);
    assign in_ready = (count < CNT_W'(DEPTH)) || pop;
    assign push     = in_valid && in_ready;
    assign illegal  = in_isRegW ? in_reg[2] : ({1'b0, in_reg} >= ACC_LIMIT);
    // Illegal destinations still occupy a slot when they carry bit writes.
    assign store    = push && (!illegal || (in_bits != 3'b000));
    assign dataSel  = isWrite ? 3'd1 : 3'd0;

    // NOTE: storage has no reset; pointers and count alone define which slots are live.
    always_ff @(posedge CLK) begin
        if (store) begin
            dataMem[wrPtr]   <= in_data;
            regMem[wrPtr]    <= in_reg;
            isRegMem[wrPtr]  <= in_isRegW;
            hasRegMem[wrPtr] <= !illegal;
            bitsMem[wrPtr]   <= in_bits;
            bitvalMem[wrPtr] <= in_bitval;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            err_addr   <= 1'b0;
            isWrite    <= 1'b0;
            writeReg   <= 3'd0;
            isRegW     <= 1'b0;
            writeData1 <= 8'd0;
            writeFlip  <= 1'b0;
            writeFlag  <= 1'b0;
            writeBit   <= 1'b0;
            flipin     <= 1'b0;
            flagin     <= 1'b0;
            bitin      <= 1'b0;
        end else begin
            err_addr <= push && illegal;
            if (store) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)   rdPtr <= rdPtr + PTR_W'(1);
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop) begin
                isWrite    <= hasRegMem[rdPtr];
                writeReg   <= regMem[rdPtr];
                isRegW     <= isRegMem[rdPtr];
                writeData1 <= dataMem[rdPtr];
                {writeFlip, writeFlag, writeBit} <= bitsMem[rdPtr];
                {flipin, flagin, bitin}          <= bitvalMem[rdPtr];
            end else begin
                isWrite    <= 1'b0;
                writeReg   <= 3'd0;
                isRegW     <= 1'b0;
                writeData1 <= 8'd0;
                {writeFlip, writeFlag, writeBit} <= 3'b000;
                {flipin, flagin, bitin}          <= 3'b000;
            end
        end
    end

`ifdef REGS_WRITEBACK_BYPASS_EN
    // Scan oldest to youngest (output stage first) so the last match is the newest value.
    function automatic logic [8:0] lookup(input logic [2:0] rdReg, input logic rdIsReg);
        logic [8:0]       result;
        logic [PTR_W-1:0] idx;
        result = 9'd0;
        if (isWrite && (writeReg == rdReg) && (isRegW == rdIsReg))
            result = {1'b1, writeData1};
        for (int k = 0; k < DEPTH; k++) begin
            idx = rdPtr + PTR_W'(k);
            if ((CNT_W'(k) < count) && hasRegMem[idx] &&
                (regMem[idx] == rdReg) && (isRegMem[idx] == rdIsReg))
                result = {1'b1, dataMem[idx]};
        end
        return result;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(rd1_reg, rd1_isReg);
        {fwd2_hit, fwd2_data} = lookup(rd2_reg, rd2_isReg);
    end
`else
    logic unusedRdPorts;
    assign unusedRdPorts = ^{rd1_reg, rd2_reg, rd1_isReg, rd2_isReg};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = 8'd0;
    assign fwd2_data = 8'd0;
`endif

endmodule

// File: doc/regs_writeback.md
Name: regs_writeback

Overview:
Write-back sequencer on the producer side of the register-file write port. Accepts write requests from execute through a valid/ready handshake and buffers them in a small in-order FIFO. Drains one request per enabled cycle onto the register-file write strobes (isWrite, writeReg, isRegW, dataSel, writeData1, flip/flag/bit writes). Optionally forwards the newest pending value to the two read ports.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
ACC_COUNT, 6, number of valid accumulator indices (0..ACC_COUNT-1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
in_valid  in  1  execute offers a write request
in_ready  out  1  request accepted this cycle when in_valid&in_ready
in_isRegW  in  1  1 = regular register, 0 = accumulator
in_reg  in  3  destination index
in_data  in  8  write data
in_bits  in  3  {writeFlip, writeFlag, writeBit} request
in_bitval  in  3  {flipin, flagin, bitin} values
drain_en  in  1  register-file port free this cycle
isWrite  out  1  write strobe to register file
writeReg  out  3  destination index
isRegW  out  1  regular/accumulator select
dataSel  out  3  constant 3'd1 while isWrite, else 3'd0
writeData1  out  8  write data
writeFlip, writeFlag, writeBit  out  1 each  single-bit strobes
flipin, flagin, bitin  out  1 each  single-bit values
rd1_reg, rd2_reg  in  3 each  read indices being decoded
rd1_isReg, rd2_isReg  in  1 each  read kinds
fwd1_hit, fwd2_hit  out  1 each  pending write matches read
fwd1_data, fwd2_data  out  8 each  newest matching pending data
count  out  log2(DEPTH)+1  occupancy
err_addr  out  1  one-cycle pulse: illegal destination rejected

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, count=0, read and write pointers 0. All strobes 0, writeReg/writeData1/dataSel 0, fwd*_hit 0, err_addr 0, in_ready 1 once released. Any in-flight entry is discarded.
- Push condition: in_valid & in_ready.
- in_ready = (count<DEPTH) | pop, combinationally. A push while full is allowed in the cycle the head pops.
- Illegal destination: either in_isRegW=0 with in_reg>=ACC_COUNT, or in_isRegW=1 with in_reg[2]=1.
  - Request is accepted (handshake completes) but not stored.
  - err_addr pulses on the next cycle.
  - An illegal request with nonzero in_bits stores only its bit writes, reg write suppressed. err_addr still pulses.
- Pop condition: drain_en & count!=0. The pop is registered, so outputs reflect the head entry popped at the previous edge (1-cycle latency).
  - Empty-to-output latency: push at edge N, earliest isWrite high in cycle N+1→N+2 with drain_en high at edge N+1.
- Registered strobes are high for exactly one cycle per popped entry.
  - isWrite is high only if the entry has a reg write.
  - writeFlip/Flag/Bit are high per the entry's bit mask.
- Pop takes effect only when drain_en is high at the edge. Otherwise outputs return to 0 the cycle after the last pop. No entry is ever emitted twice.
- Simultaneous push and pop: count unchanged. Both pointers wrap modulo DEPTH.
- Ordering is strict FIFO. Two writes to the same register are emitted in acceptance order.
- Forwarding compares rd_reg/rd_isReg against all valid FIFO entries with a reg write, plus the entry currently on the output strobes.
  - The newest match wins. Output data is the youngest entry's data.
  - A same-cycle incoming push is not forwarded.
  - No match: hit=0, data=0.
- count is exact and never exceeds DEPTH.

Optional Feature:
Macro: REGS_WRITEBACK_BYPASS_EN.
- Defined: forwarding logic as above.
- Undefined: fwd1_hit, fwd2_hit, fwd1_data, fwd2_data are tied to 0 and no comparators are built. Execute stalls on count!=0 instead.

Test Plan:
- Reset mid-operation: push 3 entries, assert RST_N low between edges → count=0 and isWrite=0 immediately; after release no stale write is emitted.
- Single write: push acc 2 data 8'hA5 with drain_en=1 → two edges later isWrite=1, isRegW=0, writeReg=2, writeData1=A5, dataSel=1 for one cycle.
- Full plus stall: with drain_en=0, push 4 entries → in_ready=0 and count=4. Raise drain_en with in_valid=1 → push and pop in the same cycle, count stays 4, outputs in order.
- Illegal destination: push acc 6 → accepted, err_addr=1 next cycle, no isWrite ever. Push regular 5 → same response.
- Forwarding (BYPASS_EN): pending reg1=8'h11 then reg1=8'h22, rd1_isReg=1, rd1_reg=1 → fwd1_hit=1, fwd1_data=8'h22. rd2 on acc 1 → fwd2_hit=0.
- Bit-only write: in_bits=3'b010, in_bitval=3'b010 → writeFlag=1 and flagin=1 for one cycle, isWrite=0.
